// File: rtl/light_mode_sequencer.sv
// Rear-light mode controller: steps OFF/ON/SLOW/FAST on button presses, adjusts the
// blinker rates with one-cycle shift pulses, and returns to OFF after an idle timeout.
module light_mode_sequencer #(
  parameter int RATE_W     = 3,
  parameter int RATE_MAX   = 4,
  parameter int SLOW_INIT  = 4,
  parameter int FAST_INIT  = 1,
  parameter int IDLE_W     = 10,
  parameter int IDLE_BEATS = 960
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              next,
  input  logic              up_button,
  input  logic              down_button,
  output logic [1:0]        mode,
  output logic              slow_left,
  output logic              slow_right,
  output logic              fast_left,
  output logic              fast_right,
  output logic [RATE_W-1:0] slow_rate,
  output logic [RATE_W-1:0] fast_rate
);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  localparam logic [RATE_W-1:0] RATE_TOP  = RATE_W'(RATE_MAX);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BEATS - 1);

  logic              next_prev_reg;
  logic              up_prev_reg;
  logic              down_prev_reg;
  logic              next_press;
  logic              up_press;
  logic              down_press;
  logic              any_press;
  logic              rate_up;
  logic              rate_down;
  logic [1:0]        mode_reg;
  logic [1:0]        mode_next;
  logic [IDLE_W-1:0] idle_reg;
  logic [IDLE_W-1:0] idle_next;

  // Index 0 is the slow blinker, index 1 the fast blinker.
  logic [1:0][RATE_W-1:0] rate_vec;
  logic [1:0]             left_vec;
  logic [1:0]             right_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_prev_reg <= 1'b0;
      up_prev_reg   <= 1'b0;
      down_prev_reg <= 1'b0;
    end else begin
      next_prev_reg <= next;
      up_prev_reg   <= up_button;
      down_prev_reg <= down_button;
    end
  end

  assign next_press = next & ~next_prev_reg;
  assign up_press   = up_button & ~up_prev_reg;
  assign down_press = down_button & ~down_prev_reg;
  assign any_press  = next_press | up_press | down_press;

  // A next press overrides rate buttons; simultaneous up and down cancel out.
  assign rate_up   = up_press & ~down_press & ~next_press;
  assign rate_down = down_press & ~up_press & ~next_press;

  always_comb begin
    mode_next = mode_reg;
    idle_next = idle_reg;
    if (next_press) begin
      case (mode_reg)
        MODE_OFF:  mode_next = MODE_ON;
        MODE_ON:   mode_next = MODE_SLOW;
        MODE_SLOW: mode_next = MODE_FAST;
        default:   mode_next = MODE_OFF;
      endcase
    end
    if (any_press || (mode_reg == MODE_OFF)) begin
      idle_next = '0;
    end else if (beat) begin
      if (idle_reg == IDLE_LAST) begin
        mode_next = MODE_OFF;
        idle_next = '0;
      end else begin
        idle_next = idle_reg + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg <= MODE_OFF;
      idle_reg <= '0;
    end else begin
      mode_reg <= mode_next;
      idle_reg <= idle_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam logic [1:0]        CH_MODE = (gi == 0) ? MODE_SLOW : MODE_FAST;
    localparam logic [RATE_W-1:0] CH_INIT = RATE_W'((gi == 0) ? SLOW_INIT : FAST_INIT);

    logic              ch_sel;
    logic [RATE_W-1:0] rate_reg;
    logic [RATE_W-1:0] rate_next;
    logic              left_reg;
    logic              left_next;
    logic              right_reg;
    logic              right_next;

    assign ch_sel = (mode_reg == CH_MODE);

    // Rates saturate at both ends; a press at a limit produces no pulse.
    always_comb begin
      rate_next  = rate_reg;
      left_next  = 1'b0;
      right_next = 1'b0;
      if (ch_sel && rate_up && (rate_reg != '0)) begin
        rate_next  = rate_reg - RATE_W'(1);
        right_next = 1'b1;
      end else if (ch_sel && rate_down && (rate_reg < RATE_TOP)) begin
        rate_next = rate_reg + RATE_W'(1);
        left_next = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rate_reg  <= CH_INIT;
        left_reg  <= 1'b0;
        right_reg <= 1'b0;
      end else begin
        rate_reg  <= rate_next;
        left_reg  <= left_next;
        right_reg <= right_next;
      end
    end

    assign rate_vec[gi]  = rate_reg;
    assign left_vec[gi]  = left_reg;
    assign right_vec[gi] = right_reg;
  end

  assign mode       = mode_reg;
  assign slow_left  = left_vec[0];
  assign slow_right = right_vec[0];
  assign fast_left  = left_vec[1];
  assign fast_right = right_vec[1];
  assign slow_rate  = rate_vec[0];
  assign fast_rate  = rate_vec[1];

endmodule
